// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control: walks each instruction through its states
// and drives the datapath enables and mux selects as Moore outputs.
module main_control_fsm (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [5:0] OPCODE,
  output logic [1:0] ALU_OP,
  output logic       PC_WRITE,
  output logic       PC_WRITE_COND,
  output logic       I_OR_D,
  output logic       MEM_READ,
  output logic       MEM_WRITE,
  output logic       IR_WRITE,
  output logic       MEM_TO_REG,
  output logic       REG_DST,
  output logic       REG_WRITE,
  output logic       ALU_SRC_A,
  output logic [1:0] ALU_SRC_B,
  output logic [1:0] PC_SOURCE,
  output logic [3:0] STATE,
  output logic       ILLEGAL
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEM_ADR = 4'd2;
  localparam logic [3:0] S_MEM_RD  = 4'd3;
  localparam logic [3:0] S_MEM_WB  = 4'd4;
  localparam logic [3:0] S_MEM_WR  = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_ALU_WB  = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDI_EX = 4'd9;
  localparam logic [3:0] S_ADDI_WB = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic [3:0] state;
  logic [3:0] state_nx;
  logic       legal;

  always_comb begin
    legal = (OPCODE == OP_R)   || (OPCODE == OP_LW) ||
            (OPCODE == OP_SW)  || (OPCODE == OP_BEQ) ||
            (OPCODE == OP_J)   || (OPCODE == OP_ADDI);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_FETCH;
      ILLEGAL <= 1'b0;
    end else begin
      state   <= state_nx;
      ILLEGAL <= (state == S_DECODE) && !legal;
    end
  end

  // Unused codes 12-15 fall back to FETCH through the default arm.
  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH: state_nx = S_DECODE;
      S_DECODE: begin
        case (OPCODE)
          OP_LW,
          OP_SW:   state_nx = S_MEM_ADR;
          OP_R:    state_nx = S_EXEC;
          OP_BEQ:  state_nx = S_BRANCH;
          OP_J:    state_nx = S_JUMP;
          OP_ADDI: state_nx = S_ADDI_EX;
          default: state_nx = S_FETCH;
        endcase
      end
      S_MEM_ADR:
        state_nx = (OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_nx = S_MEM_WB;
      S_EXEC:    state_nx = S_ALU_WB;
      S_ADDI_EX: state_nx = S_ADDI_WB;
      default:   state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    ALU_OP        = 2'b00;
    PC_WRITE      = 1'b0;
    PC_WRITE_COND = 1'b0;
    I_OR_D        = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    IR_WRITE      = 1'b0;
    MEM_TO_REG    = 1'b0;
    REG_DST       = 1'b0;
    REG_WRITE     = 1'b0;
    ALU_SRC_A     = 1'b0;
    ALU_SRC_B     = 2'b00;
    PC_SOURCE     = 2'b00;
    STATE         = state;
    case (state)
      S_FETCH: begin
        MEM_READ  = 1'b1;
        IR_WRITE  = 1'b1;
        PC_WRITE  = 1'b1;
        ALU_SRC_B = 2'b01;
      end
      S_DECODE: ALU_SRC_B = 2'b11;
      S_MEM_ADR,
      S_ADDI_EX: begin
        ALU_SRC_A = 1'b1;
        ALU_SRC_B = 2'b10;
      end
      S_MEM_RD: begin
        MEM_READ = 1'b1;
        I_OR_D   = 1'b1;
      end
      S_MEM_WR: begin
        MEM_WRITE = 1'b1;
        I_OR_D    = 1'b1;
      end
      S_MEM_WB: begin
        REG_WRITE  = 1'b1;
        MEM_TO_REG = 1'b1;
      end
      S_EXEC: begin
        ALU_SRC_A = 1'b1;
        ALU_OP    = 2'b10;
      end
      S_ALU_WB: begin
        REG_WRITE = 1'b1;
        REG_DST   = 1'b1;
      end
      S_ADDI_WB: REG_WRITE = 1'b1;
      S_BRANCH: begin
        ALU_SRC_A     = 1'b1;
        ALU_OP        = 2'b01;
        PC_WRITE_COND = 1'b1;
        PC_SOURCE     = 2'b01;
      end
      S_JUMP: begin
        PC_WRITE  = 1'b1;
        PC_SOURCE = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: directed test plan plus random instruction
// streams with occasional mid-instruction resets, against a table model.
module tb_main_control_fsm;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [5:0] OPCODE = 6'b100011;
  logic [1:0] ALU_OP;
  logic       PC_WRITE;
  logic       PC_WRITE_COND;
  logic       I_OR_D;
  logic       MEM_READ;
  logic       MEM_WRITE;
  logic       IR_WRITE;
  logic       MEM_TO_REG;
  logic       REG_DST;
  logic       REG_WRITE;
  logic       ALU_SRC_A;
  logic [1:0] ALU_SRC_B;
  logic [1:0] PC_SOURCE;
  logic [3:0] STATE;
  logic       ILLEGAL;

  main_control_fsm dut (
    .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE),
    .ALU_OP(ALU_OP), .PC_WRITE(PC_WRITE),
    .PC_WRITE_COND(PC_WRITE_COND), .I_OR_D(I_OR_D),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .IR_WRITE(IR_WRITE), .MEM_TO_REG(MEM_TO_REG),
    .REG_DST(REG_DST), .REG_WRITE(REG_WRITE),
    .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B),
    .PC_SOURCE(PC_SOURCE), .STATE(STATE), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
  } ctl_t;

  typedef int seq_t[$];

  ctl_t obs;
  always_comb begin
    obs.alu_op        = ALU_OP;
    obs.pc_write      = PC_WRITE;
    obs.pc_write_cond = PC_WRITE_COND;
    obs.i_or_d        = I_OR_D;
    obs.mem_read      = MEM_READ;
    obs.mem_write     = MEM_WRITE;
    obs.ir_write      = IR_WRITE;
    obs.mem_to_reg    = MEM_TO_REG;
    obs.reg_dst       = REG_DST;
    obs.reg_write     = REG_WRITE;
    obs.alu_src_a     = ALU_SRC_A;
    obs.alu_src_b     = ALU_SRC_B;
    obs.pc_source     = PC_SOURCE;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit prev_ill = 1'b0;

  // Control word each state must present, field by field.
  function automatic ctl_t exp_ctl(input int s);
    ctl_t c = '0;
    if (s == 0) begin
      c.mem_read = 1; c.ir_write = 1; c.pc_write = 1;
      c.alu_src_b = 2'b01;
    end
    if (s == 1) c.alu_src_b = 2'b11;
    if (s == 2 || s == 9) begin
      c.alu_src_a = 1; c.alu_src_b = 2'b10;
    end
    if (s == 3) begin c.mem_read = 1; c.i_or_d = 1; end
    if (s == 5) begin c.mem_write = 1; c.i_or_d = 1; end
    if (s == 4) begin c.reg_write = 1; c.mem_to_reg = 1; end
    if (s == 6) begin c.alu_src_a = 1; c.alu_op = 2'b10; end
    if (s == 7) begin c.reg_write = 1; c.reg_dst = 1; end
    if (s == 10) c.reg_write = 1;
    if (s == 8) begin
      c.alu_src_a = 1; c.alu_op = 2'b01;
      c.pc_write_cond = 1; c.pc_source = 2'b01;
    end
    if (s == 11) begin c.pc_write = 1; c.pc_source = 2'b10; end
    return c;
  endfunction

  function automatic seq_t path(input logic [5:0] op);
    seq_t q;
    q = '{0, 1};
    if (op == 6'b100011) q = '{0, 1, 2, 3, 4};
    if (op == 6'b101011) q = '{0, 1, 2, 5};
    if (op == 6'b000000) q = '{0, 1, 6, 7};
    if (op == 6'b001000) q = '{0, 1, 9, 10};
    if (op == 6'b000100) q = '{0, 1, 8};
    if (op == 6'b000010) q = '{0, 1, 11};
    return q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_at(input int s, input bit ill, input string tag);
    chk({tag, "/state"}, {28'b0, STATE}, s);
    chk({tag, "/ctl"}, {16'b0, obs}, {16'b0, exp_ctl(s)});
    chk({tag, "/illegal"}, {31'b0, ILLEGAL}, {31'b0, ill});
  endtask

  // Runs one instruction from FETCH; rst_at >= 0 aborts it after that step.
  task automatic run_instr(input logic [5:0] op, input int rst_at);
    seq_t q;
    string t;
    q = path(op);
    for (int i = 0; i < q.size(); i++) begin
      if (i == 0) OPCODE = op;
      t = $sformatf("op%b_s%0d", op, i);
      check_at(q[i], (i == 0) && prev_ill, t);
      if (i == rst_at) begin
        #2 RST_N = 1'b0;
        #1 check_at(0, 1'b0, {t, "_rst_async"});
        repeat (2) begin
          @(negedge CLK);
          check_at(0, 1'b0, {t, "_rst_hold"});
        end
        RST_N = 1'b1;
        prev_ill = 1'b0;
        return;
      end
      @(negedge CLK);
    end
    prev_ill = (q.size() == 2);
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    int r;
    ops = '{6'b000000, 6'b100011, 6'b101011,
            6'b000100, 6'b000010, 6'b001000};
    OPCODE = 6'b100011;
    RST_N = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check_at(0, 1'b0, "reset");
    end
    RST_N = 1'b1;
    run_instr(6'b100011, -1);
    run_instr(6'b000000, -1);
    run_instr(6'b000100, -1);
    run_instr(6'b000010, -1);
    run_instr(6'b111111, -1);
    run_instr(6'b111111, -1);
    run_instr(6'b000000, -1);
    run_instr(6'b101011, 3);
    run_instr(6'b001000, -1);
    repeat (300) begin
      r = $urandom_range(0, 7);
      if (r < 6) op = ops[r];
      else op = 6'($urandom);
      r = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : -1;
      run_instr(op, r);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
